ram_wr_arb: RTL and testbench
=============================

# ram_wr_arb

Two-requester burst arbiter for the write port of the 64x8 dual-port RAM. Each client asks for a burst (start address, length). The block grants one client at a time, round-robin, and streams that client's data onto the RAM write port (`ram_wr_en`/`ram_wr_we`/`ram_wr_addr`/`ram_wr_data`). It sits between the data producers and the RAM IP, replacing a single hard-wired write generator.

## Interface
Parameters:
- `ADDR_W`, default 6, RAM address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, default 8, RAM data width.
- `LEN_W`, default 5, burst length field width; value 0 encodes 2^LEN_W beats.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  burst request, level; held until the matching `gnt`.
- `addr0` / `addr1`  in  ADDR_W  burst start address; sampled on the grant edge.
- `len0` / `len1`  in  LEN_W  burst length; sampled on the grant edge.
- `wdata0` / `wdata1`  in  DATA_W  write data; sampled on every edge where the matching `dack` is high.
- `gnt0` / `gnt1`  out  1  registered; high for the whole burst owned by that client.
- `dack0` / `dack1`  out  1  data accept; high in a cycle means that cycle's `wdata` is consumed.
- `done0` / `done1`  out  1  one-cycle pulse after the last beat.
- `ram_wr_en`, `ram_wr_we`  out  1  registered RAM write enable; `we` always equals `en`.
- `ram_wr_addr`  out  ADDR_W  registered RAM write address.
- `ram_wr_data`  out  DATA_W  registered RAM write data.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
States:
- **IDLE**: no grant.
  - Any `req` high → latch that client's addr/len → **BURST** next cycle.
  - Both high → client selected by priority pointer.
- **BURST**: `gnt_x`=1 and `dack_x`=1 every cycle.
  - Beat counter runs from 0 to len−1.
  - Write address = start + beat, modulo 2^ADDR_W.
  - On the last beat → **GAP**.
- **GAP**: one cycle.
  - `gnt` low, `done_x`=1.
  - Priority pointer flips to the other client → **IDLE**.

Rules:
- `dack_x` = `gnt_x` AND state==BURST (combinational from registered state).
- Client drops `req` mid-burst → ignored; the burst completes.
- `addr`/`len` changes after grant → ignored.
- `req_x` still high in IDLE after `done_x` → treated as a new request, arbitrated normally.
- Minimum spacing between bursts: 2 idle-port cycles (GAP + IDLE).
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Priority pointer = client 0.
- `rst` mid-burst → next edge returns to reset values; no `done` pulse; remaining beats discarded.

## Timing
- Cycle n: IDLE, `req0`=1.
- Cycle n+1: `gnt0`=`dack0`=1, beat 0; `wdata0` sampled at end of n+1.
- Cycle n+2: `ram_wr_en`=1, `ram_wr_addr`=addr0, `ram_wr_data`=beat-0 data.
- RAM write latency from `dack` cycle: 1 clock.
- Burst of L beats: `gnt` high L cycles.
  - `done` pulses in cycle n+L+1.
  - Last RAM write is also in cycle n+L+1.
- `ram_wr_en` low in every cycle not following a `dack` cycle.

## Configuration
- Macro `RAM_WR_ARB_FIXED_PRIO_EN`.
- Defined:
  - Client 0 always wins simultaneous requests.
  - Pointer logic is removed.
- Undefined (default):
  - Round-robin via the pointer.
  - After serving client x, the other client wins the next tie.

## Test plan
- Single burst: `req0`, addr0=10, len0=4, data A0..A3 → `gnt0` 4 cycles; RAM writes addr 10..13 = A0..A3, one per cycle starting 2 cycles after req; `done0` 1 cycle.
- Wrap-around: `req1`, addr1=62, len1=4 → RAM writes addr 62, 63, 0, 1.
- Length encoding: len0=0 → 32 beats, `gnt0` high exactly 32 cycles; 32 writes.
- Simultaneous requests, both held, len=2 each, from reset:
  - Default build: grant order 0,1,0,1.
  - `RAM_WR_ARB_FIXED_PRIO_EN`: 0,0,0 while `req0` held.
- Mid-burst events:
  - `req0` dropped after beat 1 of len 8 → all 8 writes occur.
  - `rst` asserted at beat 3 → next cycle all outputs 0, no `done0`, `busy`=0; a subsequent tie is granted to client 0.

Source files
------------

// File: rtl/ram_wr_arb_if.sv
// Burst-request / RAM write-port bundle for ram_wr_arb.
// slave = arbiter side, master = producers plus RAM observer side.
interface ram_wr_arb_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              dack0;
  logic              dack1;
  logic              done0;
  logic              done1;
  logic              ram_wr_en;
  logic              ram_wr_we;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              busy;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, wdata0, wdata1,
    output gnt0, gnt1, dack0, dack1, done0, done1,
           ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data, busy
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1, wdata0, wdata1,
    input  gnt0, gnt1, dack0, dack1, done0, done1,
           ram_wr_en, ram_wr_we, ram_wr_addr, ram_wr_data, busy
  );
endinterface

// File: rtl/ram_wr_arb.sv
// Two-client round-robin burst arbiter driving the write port of a dual-port RAM.
// Define RAM_WR_ARB_FIXED_PRIO_EN to make client 0 always win ties (no pointer).
module ram_wr_arb #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic          clk,
  input  logic          rst,
  ram_wr_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state_q;
  logic              owner_q;
  logic [ADDR_W-1:0] start_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              done0_q;
  logic              done1_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
`ifndef RAM_WR_ARB_FIXED_PRIO_EN
  logic              ptr_q;
`endif

  logic              any_req_d;
  logic              pick1_d;
  logic              dack0_d;
  logic              dack1_d;
  logic              last_beat_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wdata_d;

  always_comb begin
    any_req_d = bus.req0 | bus.req1;
`ifdef RAM_WR_ARB_FIXED_PRIO_EN
    pick1_d   = bus.req1 & ~bus.req0;
`else
    // On a tie the pointer names the client that has waited longest.
    pick1_d   = bus.req1 & (~bus.req0 | ptr_q);
`endif
    dack0_d     = gnt0_q & (state_q == S_BURST);
    dack1_d     = gnt1_q & (state_q == S_BURST);
    wdata_d     = owner_q ? bus.wdata1 : bus.wdata0;
    wr_addr_d   = start_q + ADDR_W'(beat_q);
    // len 0 wraps to all-ones here, giving the full 2^LEN_W beat burst.
    last_beat_d = (beat_q == (len_q - LEN_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      start_q   <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifndef RAM_WR_ARB_FIXED_PRIO_EN
      ptr_q     <= 1'b0;
`endif
    end else begin
      wr_en_q <= dack0_d | dack1_d;
      if (dack0_d | dack1_d) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wdata_d;
      end
      done0_q <= 1'b0;
      done1_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            owner_q <= pick1_d;
            start_q <= pick1_d ? bus.addr1 : bus.addr0;
            len_q   <= pick1_d ? bus.len1 : bus.len0;
            beat_q  <= '0;
            gnt0_q  <= ~pick1_d;
            gnt1_q  <= pick1_d;
            state_q <= S_BURST;
          end
        end
        S_BURST: begin
          if (last_beat_d) begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= S_GAP;
          end else begin
            beat_q <= beat_q + LEN_W'(1);
          end
        end
        S_GAP: begin
`ifndef RAM_WR_ARB_FIXED_PRIO_EN
          ptr_q   <= ~owner_q;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.dack0       = dack0_d;
  assign bus.dack1       = dack1_d;
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_we   = wr_en_q;
  assign bus.ram_wr_addr = wr_addr_q;
  assign bus.ram_wr_data = wr_data_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_wr_arb.sv
// Directed bench for ram_wr_arb: single, wrapping, full-length, tie, mid-burst
// drop and mid-burst reset scenarios with hand-computed expectations.
module tb_ram_wr_arb;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_wr_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  ram_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor state
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int gnt_seq[$];
  int gnt_cyc[$];
  int g0cyc, g1cyc, dk0, dk1, dn0, dn1, done_cyc, we_err;
  logic pg0 = 1'b0;
  logic pg1 = 1'b0;

  // Producer data state
  int seed0 = 0, cnt0 = 0, seed1 = 0, cnt1 = 0;

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    gnt_seq.delete(); gnt_cyc.delete();
    g0cyc = 0; g1cyc = 0; dk0 = 0; dk1 = 0; dn0 = 0; dn1 = 0;
    done_cyc = -1; we_err = 0;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      if (bus.ram_wr_we !== bus.ram_wr_en) we_err++;
      if (bus.ram_wr_en === 1'b1) begin
        wr_addr_q.push_back(int'(bus.ram_wr_addr));
        wr_data_q.push_back(int'(bus.ram_wr_data));
        wr_cyc_q.push_back(cyc);
      end
      if (bus.gnt0 === 1'b1) g0cyc++;
      if (bus.gnt1 === 1'b1) g1cyc++;
      if (bus.dack0 === 1'b1) dk0++;
      if (bus.dack1 === 1'b1) dk1++;
      if (bus.done0 === 1'b1) begin dn0++; done_cyc = cyc; end
      if (bus.done1 === 1'b1) begin dn1++; done_cyc = cyc; end
      if (bus.gnt0 === 1'b1 && pg0 !== 1'b1) begin gnt_seq.push_back(0); gnt_cyc.push_back(cyc); end
      if (bus.gnt1 === 1'b1 && pg1 !== 1'b1) begin gnt_seq.push_back(1); gnt_cyc.push_back(cyc); end
      pg0 = bus.gnt0;
      pg1 = bus.gnt1;
    end
  end

  // Producers present the next word whenever their dack is up.
  initial begin
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    forever begin
      @(negedge clk);
      if (bus.dack0 === 1'b1) begin bus.wdata0 = DATA_W'(seed0 + cnt0); cnt0++; end
      if (bus.dack1 === 1'b1) begin bus.wdata1 = DATA_W'(seed1 + cnt1); cnt1++; end
    end
  end

  task automatic wait_gnt(input int c, input int max);
    int n = 0;
    while ((((c == 0) ? bus.gnt0 : bus.gnt1) !== 1'b1) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) chk("wait_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (bus.busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) chk("wait_idle_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_gnt0"},  32'(bus.gnt0),  32'd0);
    chk({pfx, "_gnt1"},  32'(bus.gnt1),  32'd0);
    chk({pfx, "_dack0"}, 32'(bus.dack0), 32'd0);
    chk({pfx, "_dack1"}, 32'(bus.dack1), 32'd0);
    chk({pfx, "_done0"}, 32'(bus.done0), 32'd0);
    chk({pfx, "_done1"}, 32'(bus.done1), 32'd0);
    chk({pfx, "_en"},    32'(bus.ram_wr_en), 32'd0);
    chk({pfx, "_we"},    32'(bus.ram_wr_we), 32'd0);
    chk({pfx, "_addr"},  32'(bus.ram_wr_addr), 32'd0);
    chk({pfx, "_data"},  32'(bus.ram_wr_data), 32'd0);
    chk({pfx, "_busy"},  32'(bus.busy), 32'd0);
  endtask

  initial begin
    int t0;
    int n;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.len0 = '0;   bus.len1 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single burst: client 0, addr 10, len 4, data A0..A3
    clear_mon(); seed0 = 'hA0; cnt0 = 0;
    bus.req0 = 1'b1; bus.addr0 = 6'd10; bus.len0 = 5'd4; t0 = cyc;
    @(negedge clk);
    wait_gnt(0, 10);
    chk("t1_gnt_cyc", 32'(cyc), 32'(t0 + 1));
    bus.req0 = 1'b0;
    wait_idle(60);
    chk("t1_gnt_len", 32'(g0cyc), 32'd4);
    chk("t1_dack_cnt", 32'(dk0), 32'd4);
    chk("t1_done_cnt", 32'(dn0), 32'd1);
    chk("t1_done_cyc", 32'(done_cyc), 32'(t0 + 5));
    chk("t1_nwr", 32'(wr_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), 32'(wr_addr_q[i]), 32'(10 + i));
      chk($sformatf("t1_data%0d", i), 32'(wr_data_q[i]), 32'('hA0 + i));
    end
    chk("t1_first_wr_cyc", 32'(wr_cyc_q[0]), 32'(t0 + 2));
    chk("t1_last_wr_cyc", 32'(wr_cyc_q[3]), 32'(t0 + 5));
    chk("t1_we_eq_en", 32'(we_err), 32'd0);

    // Wrap-around: client 1, addr 62, len 4
    clear_mon(); seed1 = 'h50; cnt1 = 0;
    bus.req1 = 1'b1; bus.addr1 = 6'd62; bus.len1 = 5'd4;
    @(negedge clk);
    wait_gnt(1, 10);
    bus.req1 = 1'b0;
    wait_idle(60);
    chk("t2_nwr", 32'(wr_addr_q.size()), 32'd4);
    chk("t2_addr0", 32'(wr_addr_q[0]), 32'd62);
    chk("t2_addr1", 32'(wr_addr_q[1]), 32'd63);
    chk("t2_addr2", 32'(wr_addr_q[2]), 32'd0);
    chk("t2_addr3", 32'(wr_addr_q[3]), 32'd1);
    chk("t2_data3", 32'(wr_data_q[3]), 32'h53);
    chk("t2_done1", 32'(dn1), 32'd1);
    chk("t2_gnt0_idle", 32'(g0cyc), 32'd0);

    // Length 0 means 32 beats
    clear_mon(); seed0 = 0; cnt0 = 0;
    bus.req0 = 1'b1; bus.addr0 = 6'd5; bus.len0 = 5'd0;
    @(negedge clk);
    wait_gnt(0, 10);
    bus.req0 = 1'b0;
    wait_idle(80);
    chk("t3_gnt_len", 32'(g0cyc), 32'd32);
    chk("t3_nwr", 32'(wr_addr_q.size()), 32'd32);
    chk("t3_last_addr", 32'(wr_addr_q[31]), 32'd36);
    chk("t3_last_data", 32'(wr_data_q[31]), 32'd31);

    // Tie from reset, both held, len 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_mon(); seed0 = 'h10; cnt0 = 0; seed1 = 'h20; cnt1 = 0;
    bus.req0 = 1'b1; bus.addr0 = 6'd0;  bus.len0 = 5'd2;
    bus.req1 = 1'b1; bus.addr1 = 6'd32; bus.len1 = 5'd2;
    n = 0;
    while (gnt_seq.size() < 4 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("t4_timeout", 32'd0, 32'd1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle(60);
`ifdef RAM_WR_ARB_FIXED_PRIO_EN
    chk("t4_seq0", 32'(gnt_seq[0]), 32'd0);
    chk("t4_seq1", 32'(gnt_seq[1]), 32'd0);
    chk("t4_seq2", 32'(gnt_seq[2]), 32'd0);
    chk("t4_wr2_addr", 32'(wr_addr_q[2]), 32'd0);
`else
    chk("t4_seq0", 32'(gnt_seq[0]), 32'd0);
    chk("t4_seq1", 32'(gnt_seq[1]), 32'd1);
    chk("t4_seq2", 32'(gnt_seq[2]), 32'd0);
    chk("t4_seq3", 32'(gnt_seq[3]), 32'd1);
    chk("t4_wr2_addr", 32'(wr_addr_q[2]), 32'd32);
    chk("t4_wr2_data", 32'(wr_data_q[2]), 32'h20);
`endif
    chk("t4_spacing", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd4);

    // req0 dropped after beat 1 of len 8; addr/len changed after grant
    clear_mon(); seed0 = 'h70; cnt0 = 0;
    bus.req0 = 1'b1; bus.addr0 = 6'd20; bus.len0 = 5'd8;
    @(negedge clk);
    wait_gnt(0, 10);
    @(negedge clk);
    bus.req0 = 1'b0; bus.addr0 = 6'd40; bus.len0 = 5'd3;
    wait_idle(60);
    chk("t5_nwr", 32'(wr_addr_q.size()), 32'd8);
    chk("t5_addr7", 32'(wr_addr_q[7]), 32'd27);
    chk("t5_data7", 32'(wr_data_q[7]), 32'h77);
    chk("t5_gnt_len", 32'(g0cyc), 32'd8);

    // Reset at beat 3 of a len-8 burst, then a tie goes to client 0
    clear_mon(); seed0 = 'h90; cnt0 = 0;
    bus.req0 = 1'b1; bus.addr0 = 6'd0; bus.len0 = 5'd8;
    @(negedge clk);
    wait_gnt(0, 10);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("t6");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_done", 32'(dn0), 32'd0);
    chk("t6_nwr", 32'(wr_addr_q.size()), 32'd3);
    bus.req0 = 1'b1; bus.addr0 = 6'd8;  bus.len0 = 5'd1;
    bus.req1 = 1'b1; bus.addr1 = 6'd48; bus.len1 = 5'd1;
    n = 0;
    while (bus.gnt0 !== 1'b1 && bus.gnt1 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t6_tie_gnt0", 32'(bus.gnt0), 32'd1);
    chk("t6_tie_gnt1", 32'(bus.gnt1), 32'd0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
